// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice over a WIDTH-bit operation.
// Optional abort input is enabled by defining ALUCTRL_ABORT_EN.
module bitserial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALUCTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [1:0]       slice_sel,
    output logic             slice_inv,
    input  logic             slice_sum,
    input  logic             slice_cout,
    input  logic             slice_set
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       op_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic             legal_op;
    logic             is_logic;
    logic             final_ov;
    logic [WIDTH-1:0] shifted_res;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        legal_op = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_SLT);
        is_logic = (op_reg[2:1] == 2'b00);
    end

    always_comb begin
        slice_a    = a_sh[0];
        slice_b    = b_sh[0];
        slice_cin  = carry_reg;
        slice_inv  = op_reg[2];
        slice_less = 1'b0;
        slice_sel  = is_logic ? {1'b0, op_reg[0]} : 2'b10;
    end

    // SLT takes the true sign of a-b: raw adder sum corrected by overflow.
    always_comb begin
        final_ov    = carry_reg ^ slice_cout;
        shifted_res = {slice_sum, res_sh[WIDTH-1:1]};
        if (op_reg == OP_SLT)
            final_res = {{(WIDTH-1){1'b0}}, slice_set ^ final_ov};
        else
            final_res = shifted_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_reg    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        op_reg    <= op;
                        carry_reg <= op[2];
                        cnt       <= '0;
                        if (legal_op) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            result   <= '0;
                            cout     <= 1'b0;
                            overflow <= 1'b0;
                            zero     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_sh    <= shifted_res;
                    carry_reg <= slice_cout;
                    a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt       <= cnt + CW'(1);
`ifdef ALUCTRL_ABORT_EN
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else
`endif
                    if (cnt == LAST_BIT) begin
                        cout     <= is_logic ? 1'b0 : slice_cout;
                        overflow <= is_logic ? 1'b0 : final_ov;
                        result   <= final_res;
                        zero     <= (final_res == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Directed self-checking bench for bitserial_alu_ctrl with a behavioural 1-bit ALU slice.
// Abort scenario is exercised when ALUCTRL_ABORT_EN is defined.
module tb_bitserial_alu_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ALUCTRL_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_less;
    logic [1:0]       slice_sel;
    logic             slice_inv;
    logic             slice_sum;
    logic             slice_cout;
    logic             slice_set;

    int assertCount = 0;
    int failCount   = 0;

    bitserial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
`ifdef ALUCTRL_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .overflow   (overflow),
        .zero       (zero),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_less (slice_less),
        .slice_sel  (slice_sel),
        .slice_inv  (slice_inv),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .slice_set  (slice_set)
    );

    // Behavioural model of the external ALU slice the sequencer drives.
    logic slice_bb;
    logic slice_add;
    always_comb begin
        slice_bb   = slice_b ^ slice_inv;
        slice_add  = slice_a ^ slice_bb ^ slice_cin;
        slice_cout = (slice_a & slice_bb) | (slice_a & slice_cin) | (slice_bb & slice_cin);
        slice_set  = slice_add;
        case (slice_sel)
            2'b00:   slice_sum = slice_a & slice_bb;
            2'b01:   slice_sum = slice_a | slice_bb;
            2'b10:   slice_sum = slice_add;
            default: slice_sum = slice_less;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request for a single edge, then scrambles the inputs to prove they were captured.
    task automatic applyStimulus(input logic [2:0] opv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        op    = opv;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
    endtask

    task automatic waitDone(input string tag, input int expLat);
        int j;
        j = 0;
        while (!done && j <= 100) begin
            @(negedge clk);
            j++;
        end
        checkOutput({tag, "_latency"}, 32'(j), 32'(expLat));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic checkFlags(input string tag, input logic [31:0] expRes, input logic expCout,
                              input logic expOv, input logic expZero);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_cout"}, {31'b0, cout}, {31'b0, expCout});
        checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, expOv});
        checkOutput({tag, "_zero"}, {31'b0, zero}, {31'b0, expZero});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
`ifdef ALUCTRL_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkFlags("reset", 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3'b010, 32'h7FFFFFFF, 32'h00000001);
        checkOutput("add_busy", {31'b0, busy}, 32'd1);
        waitDone("add_ovf", 32);
        checkFlags("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);

        applyStimulus(3'b011, 32'h12345678, 32'h1);
        waitDone("illegal", 0);
        checkFlags("illegal", 32'h0, 1'b0, 1'b0, 1'b1);

        applyStimulus(3'b110, 32'd5, 32'd5);
        checkOutput("sub_inv", {31'b0, slice_inv}, 32'd1);
        checkOutput("sub_cin", {31'b0, slice_cin}, 32'd1);
        checkOutput("sub_sel", {30'b0, slice_sel}, 32'd2);
        checkOutput("sub_less", {31'b0, slice_less}, 32'd0);
        waitDone("sub", 32);
        checkFlags("sub", 32'h0, 1'b1, 1'b0, 1'b1);

        applyStimulus(3'b111, 32'hFFFFFFFD, 32'd2);
        waitDone("slt_neg", 32);
        checkFlags("slt_neg", 32'h1, 1'b1, 1'b0, 1'b0);

        applyStimulus(3'b111, 32'h7FFFFFFF, 32'h80000000);
        waitDone("slt_ovf", 32);
        checkFlags("slt_ovf", 32'h0, 1'b0, 1'b1, 1'b1);

        applyStimulus(3'b111, 32'd2, 32'd2);
        waitDone("slt_eq", 32);
        checkFlags("slt_eq", 32'h0, 1'b1, 1'b0, 1'b1);

        applyStimulus(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0);
        checkOutput("and_sel", {30'b0, slice_sel}, 32'd0);
        waitDone("and", 32);
        checkFlags("and", 32'h00F000F0, 1'b0, 1'b0, 1'b0);

        applyStimulus(3'b001, 32'hF0F0F0F0, 32'h0FF00FF0);
        waitDone("or", 32);
        checkFlags("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);

        // A second request mid-operation must not disturb the one in flight.
        applyStimulus(3'b010, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 3'b001;
        a     = 32'hFFFF0000;
        b     = 32'h1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("midstart_busy", {31'b0, busy}, 32'd1);
        waitDone("midstart", 26);
        checkFlags("midstart", 32'h7, 1'b0, 1'b0, 1'b0);

`ifdef ALUCTRL_ABORT_EN
        applyStimulus(3'b010, 32'd10, 32'd20);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen++;
            end
            checkOutput("abort_no_done", 32'(seen), 32'd0);
        end
        checkFlags("abort_hold", 32'h7, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 32'd10, 32'd20);
        waitDone("after_abort", 32);
        checkFlags("after_abort", 32'd30, 1'b0, 1'b0, 1'b0);
`endif

        applyStimulus(3'b010, 32'd1, 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_done", {31'b0, done}, 32'd0);
        checkFlags("midreset", 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            checkOutput("midreset_no_done", 32'(seen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bitserial_alu_ctrl.md
Name: bitserial_alu_ctrl

Overview:
Sequencer that time-multiplexes one external 1-bit ALU slice (AND / OR / ADD-SUB / SLT slice with b-invert, carry in/out, set and less pins) over a WIDTH-bit operation, one bit per cycle from LSB to MSB. It holds carry, operand and result shift registers. It derives overflow, carry-out, zero and the SLT result, and presents a start/done handshake to the datapath. It sits between the control unit and a single slice instance, in place of a WIDTH-slice ripple ALU.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  registered result, held until next accepted start
cout  output  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow  output  1  signed overflow (ADD/SUB/SLT), else 0
zero  output  1  result == 0
slice_a  output  1  to slice a
slice_b  output  1  to slice b
slice_cin  output  1  to slice cin
slice_less  output  1  to slice less; constant 0
slice_sel  output  2  to slice sel: 00 AND, 01 OR, 10 add path
slice_inv  output  1  to slice inv
slice_sum  input  1  from slice sum
slice_cout  input  1  from slice cout
slice_set  input  1  from slice set (raw adder sum)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, cout=0, overflow=0, zero=1. Shifters, carry and bit counter cleared. Reset during RUN abandons the operation; no done.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, capture a, b and op into shifters. Set the carry register to op[2] (1 for SUB/SLT). Set bit counter to 0 and go to RUN. Illegal op: go directly to DONE with result=0, cout=0, overflow=0, zero=1.
- RUN, combinational slice drive:
  - slice_a = a_sh[0], slice_b = b_sh[0], slice_cin = carry_reg, slice_inv = op[2].
  - slice_sel = 00 for AND, 01 for OR, 10 for ADD/SUB/SLT.
  - slice_less = 0 always.
- RUN, each edge:
  - res_sh <= {slice_sum, res_sh[WIDTH-1:1]}; carry_reg <= slice_cout.
  - Shift a_sh and b_sh right by 1; counter++.
- RUN, edge with counter == WIDTH-1 (MSB):
  - cout <= slice_cout (AND/OR: 0).
  - overflow <= carry_reg ^ slice_cout (AND/OR: 0).
  - ADD/SUB/AND/OR: result <= {slice_sum, res_sh[WIDTH-1:1]}.
  - SLT: result <= {WIDTH-1 zeros, slice_set ^ (carry_reg ^ slice_cout)}.
  - zero from the final result value; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start during DONE is ignored.
- Latency: done is high in the cycle after edge k0+WIDTH, where k0 is the start-accept edge. Throughput is one op per WIDTH+2 cycles.
- start while busy or in DONE is ignored; a/b/op changes after accept have no effect.
- result/flags change only at the MSB edge (or the illegal-op accept edge).

Optional Feature:
ALUCTRL_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 on an edge in RUN returns to IDLE; done not pulsed; result/flags keep previous values. abort is ignored in IDLE/DONE.
- Undefined: no abort port; RUN always runs to completion.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, cout=0, zero=0; done exactly 32 cycles after the accept edge, single-cycle pulse.
- SUB a=5, b=5 -> result=0, zero=1, cout=1, overflow=0; slice_inv=1 and slice_cin=1 on the first RUN cycle.
- SLT a=0xFFFFFFFD, b=2 -> result=1. SLT a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow path). SLT a=2, b=2 -> result=0, zero=1.
- AND a=0xF0F0F0F0, b=0x0FF00FF0 -> 0x00F000F0. OR on the same operands -> 0xFFF0FFF0; cout=0, overflow=0.
- start pulsed again mid-RUN with new operands -> ignored; original result delivered; illegal op=011 -> done on the next cycle, result=0, zero=1. rst_n low mid-RUN -> all outputs at reset values immediately, no done.
- With ALUCTRL_ABORT_EN: abort at bit 10 of an ADD -> IDLE, no done, result holds the prior op's value; a new start then completes normally.
